// File: rtl/i2s_tx_stereo.sv
// I2S stereo transmitter: sample-pair FIFO feeding a left/right shadow pair, serialised MSB first
// with a one-bit delay after each word_select edge. Optional macro I2S_TX_TEST_TONE_EN fills underruns with a sawtooth.
module i2s_tx_stereo #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        reset,
  input  logic                        s_clk,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_left,
  input  logic signed [DATA_W-1:0]    in_right,
  output logic                        word_select,
  output logic                        sound_bit_out,
  output logic [$clog2(2*SLOT_W)-1:0] bit_counter,
  output logic                        frame_start,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int KW = $clog2(2*SLOT_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2*SLOT_W - 1);
  localparam logic [KW-1:0] K_SLOT = KW'(SLOT_W);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  logic [KW-1:0]            k_q, k_d, p_d;
  logic                     ws_q, ws_d;
  logic                     sdo_q, sdo_d;
  logic                     fs_q, ur_q, ur_d;
  logic signed [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic signed [DATA_W-1:0] chan, fill;
  logic signed [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic signed [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]            wr_q, rd_q;
  logic [LW-1:0]            cnt_q, cnt_d;
  logic                     load, empty, full, push, pop;

`ifdef I2S_TX_TEST_TONE_EN
  logic [DATA_W-1:0] tone_q;

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      tone_q <= '0;
    end else if (load && empty) begin
      tone_q <= (tone_q < DATA_W'(4090)) ? tone_q + DATA_W'(100) : '0;
    end
  end

  assign fill = $signed(tone_q);
`else
  assign fill = '0;
`endif

  // Outputs are registered, so every value below is derived from the next frame position.
  always_comb begin
    load  = (k_q == K_LAST);
    empty = (cnt_q == '0);
    full  = (cnt_q == L_FULL);
    push  = in_valid && !full;
    pop   = load && !empty;
    k_d   = load ? '0 : k_q + KW'(1);
    ws_d  = (k_d >= K_SLOT);
    p_d   = ws_d ? k_d - K_SLOT : k_d;
    chan  = ws_d ? sh_r_q : sh_l_q;
    sdo_d = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (p_d == KW'(DATA_W - i)) sdo_d = chan[i];
    end
    ur_d   = load && empty;
    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    if (load) begin
      sh_l_d = empty ? fill : mem_l[rd_q];
      sh_r_d = empty ? fill : mem_r[rd_q];
    end
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + LW'(1);
    else if (!push && pop) cnt_d = cnt_q - LW'(1);
  end

  always_ff @(posedge s_clk) begin
    if (push) begin
      mem_l[wr_q] <= in_left;
      mem_r[wr_q] <= in_right;
    end
  end

  // A reset flushes the FIFO through its pointers; the storage array itself is left alone.
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      k_q    <= '0;
      ws_q   <= 1'b0;
      sdo_q  <= 1'b0;
      fs_q   <= 1'b1;
      ur_q   <= 1'b0;
      sh_l_q <= '0;
      sh_r_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      k_q    <= k_d;
      ws_q   <= ws_d;
      sdo_q  <= sdo_d;
      fs_q   <= load;
      ur_q   <= ur_d;
      sh_l_q <= sh_l_d;
      sh_r_q <= sh_r_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready      = ~full;
  assign word_select   = ws_q;
  assign sound_bit_out = sdo_q;
  assign bit_counter   = k_q;
  assign frame_start   = fs_q;
  assign underrun      = ur_q;
  assign fifo_level    = cnt_q;

endmodule
